// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner_pkg
//  Description : Shared constants for the push-button front end: button bit
//                positions and the auto-repeat state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_conditioner_pkg;

    localparam int NUM_BTN   = 6;

    // Bit positions inside the {mode,set,up,down,left,right} button vector
    localparam int BTN_MODE  = 5;
    localparam int BTN_SET   = 4;
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

    // Auto-repeat channel state
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rpt_state_t;

endpackage : button_conditioner_pkg
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
//  Module      : button_channel
//  Description : One button lane: 2-flop synchronizer, ms-tick debouncer,
//                press-pulse generator and optional auto-repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ms_pulse,
    input  logic btn,
    output logic press,
    output logic level
);

    localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
    localparam int HOLD_W = (REPEAT_DELAY_MS > 1) ? $clog2(REPEAT_DELAY_MS) : 1;

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS);

    logic              sync0;
    logic              sync1;
    logic              stable;
    logic [DB_W-1:0]   db_cnt;
    logic              db_done;
    logic              rise;
    logic              fall;

    rpt_state_t        state;
    rpt_state_t        state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              repeat_fire;

    // The stable state flips on this cycle: mismatch seen on the last qualifying tick
    assign db_done = ms_pulse && (sync1 != stable) && (db_cnt == DB_LAST);
    assign rise    = db_done &&  sync1;
    assign fall    = db_done && !sync1;

    // Two-flop synchronizer for the asynchronous raw button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
        end
    end

    // Debouncer: count ticks of continuous disagreement, any agreement restarts
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (sync1 == stable) begin
            db_cnt <= '0;
        end else if (ms_pulse) begin
            if (db_cnt == DB_LAST) begin
                stable <= sync1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Auto-repeat state and hold-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Auto-repeat next-state: first repeat after the delay, then every rate ticks;
    // a release always beats a repeat due on the same tick
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        repeat_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (rise && REPEAT_EN) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end
            end
            HOLD: begin
                if (fall || !stable) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end else if (ms_pulse) begin
                    if (hold_cnt == HOLD_LAST) begin
                        repeat_fire   = 1'b1;
                        hold_cnt_next = HOLD_RELOAD;
                    end else begin
                        hold_cnt_next = hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    // Registered one-cycle event: debounced press or auto-repeat
    always_ff @(posedge clk) begin
        if (rst) begin
            press <= 1'b0;
        end else begin
            press <= rise | repeat_fire;
        end
    end

    assign level = stable;

endmodule : button_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Six-button input stage; one independent button_channel per
//                bit, auto-repeat enabled per bit by REPEAT_MASK.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int               DEBOUNCE_MS     = 20,
    parameter int               REPEAT_DELAY_MS = 500,
    parameter int               REPEAT_RATE_MS  = 100,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK   = 6'b001100
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ms_pulse,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_level
);

    // The reload value of the hold counter would underflow otherwise
    if (REPEAT_RATE_MS > REPEAT_DELAY_MS) begin : g_bad_rate
        $error("button_conditioner: REPEAT_RATE_MS must not exceed REPEAT_DELAY_MS");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_channel (
            .clk      (i_clk),
            .rst      (i_rst),
            .ms_pulse (i_ms_pulse),
            .btn      (i_btn[i]),
            .press    (o_press[i]),
            .level    (o_level[i])
        );
    end

endmodule : button_conditioner
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Front-end input stage that feeds the clock top level. It takes six raw, asynchronous push-button levels: mode, set, up, down, left, right. For each button it synchronizes, debounces on the shared millisecond tick, and emits one-cycle press pulses, so each mode/edit module sees exactly one event per physical press. Selected buttons (up/down by default) also produce auto-repeat pulses while held, which supports fast value editing.

## Interface
Parameters:
- DEBOUNCE_MS, 20: consecutive ms ticks an input must differ from the stable state before the state flips.
- REPEAT_DELAY_MS, 500: ticks of continuous hold before the first auto-repeat pulse.
- REPEAT_RATE_MS, 100: ticks between subsequent auto-repeat pulses.
- REPEAT_MASK, 6'b001100: per-button auto-repeat enable, bit order {mode,set,up,down,left,right}.

Ports:
- i_clk, input, 1: system clock; one clock.
- i_rst, input, 1: reset, synchronous and active-high.
- i_ms_pulse, input, 1: one-cycle tick every millisecond, from the ms pulse generator.
- i_btn, input, 6: raw asynchronous buttons {mode,set,up,down,left,right}, active-high.
- o_press, output, 6: one-cycle pulse per debounced press or auto-repeat, same bit order.
- o_level, output, 6: debounced button level.

## Operation
- Per-button synchronizer: 2 flip-flops (sync0, sync1). Only sync1 is used downstream.
- Per-button debouncer:
  - Holds a stable state and a tick counter of width $clog2(DEBOUNCE_MS+1).
  - While sync1 == stable, the counter is cleared every cycle, ticks or not.
  - While sync1 != stable, the counter increments on each i_ms_pulse.
  - On an i_ms_pulse cycle with mismatch and count == DEBOUNCE_MS-1:
    - stable <= sync1;
    - counter <= 0.
  - A glitch shorter than DEBOUNCE_MS ticks restarts the count and never flips stable.
- Press pulse: asserted on the same edge at which stable goes 0 -> 1. A 1 -> 0 transition produces no pulse.
- Auto-repeat (only for bits with REPEAT_MASK = 1). Two states per channel:
  - IDLE:
    - Entered on reset and whenever stable == 0.
    - The transition stable 0 -> 1 moves the channel to HOLD, with the hold counter at 0.
  - HOLD:
    - The hold counter increments on each i_ms_pulse.
    - On the tick where count reaches REPEAT_DELAY_MS-1, emit a pulse and reload the counter to REPEAT_DELAY_MS-REPEAT_RATE_MS.
    - After the reload, a pulse is emitted every REPEAT_RATE_MS ticks.
    - stable going 0 returns the channel to IDLE on that edge; no pulse is emitted.
- Hold-counter width: $clog2(REPEAT_DELAY_MS).
- REPEAT_RATE_MS must be ≤ REPEAT_DELAY_MS (elaboration-time check). All channels are independent.

## Timing
- Reset values: o_press = 0; o_level = 0; sync regs = 0; all counters = 0; repeat FSMs = IDLE.
- Press latency from a clean raw edge is 2 cycles (sync), then DEBOUNCE_MS ticks. o_press rises on the edge of the final qualifying tick.
  - That is, between (DEBOUNCE_MS-1) ms + 3 cycles and DEBOUNCE_MS ms + 3 cycles after the raw edge, depending on tick phase.
- o_level changes on the same edge as the o_press rise; o_press is high for exactly 1 cycle.
- First repeat pulse arrives REPEAT_DELAY_MS ticks after the press pulse; later repeats follow every REPEAT_RATE_MS ticks.
- Simultaneous presses on several buttons: each bit pulses independently, possibly in the same cycle. No priority, no suppression.
- Release on the same tick a repeat would fire: release wins and no pulse is emitted. Release is detected via stable, which itself lags by the debounce.
- i_rst mid-debounce or mid-hold: all state clears on the next edge. A button still held after reset produces a fresh press after debounce.
- i_ms_pulse held constantly high (test mode): debounce behaves as DEBOUNCE_MS cycles; legal.

## Structure
- Shared package holds:
  - localparams for button bit positions (BTN_MODE=5, BTN_SET=4, BTN_UP=3, BTN_DOWN=2, BTN_LEFT=1, BTN_RIGHT=0);
  - the repeat-FSM state encoding (IDLE=1'b0, HOLD=1'b1).
- One natural sub-module, button_channel: synchronizer, debouncer, repeat FSM for one bit, with a REPEAT_EN parameter. It is instantiated 6× in a generate loop with REPEAT_EN = REPEAT_MASK[i].
- Top level: wiring only.

## Test plan
The bench uses DEBOUNCE_MS=3, REPEAT_DELAY_MS=8, REPEAT_RATE_MS=4, i_ms_pulse every 10 cycles, unless noted otherwise.
- Reset check: i_rst high 2 cycles with i_btn=6'h3F. Required: o_press=0 and o_level=0 throughout reset; one pulse per bit after the 3rd tick following release.
- Clean press of set (bit 4), held 5 ticks then released:
  - exactly one o_press[4] cycle, on the 3rd tick after sync;
  - o_level[4] falls 3 ticks after release;
  - no second pulse.
- Glitch on left: 2-tick high pulse on i_btn[1]. Required: no o_press, o_level[1] stays 0. A bounce pattern 1,0,1 within the first 2 ticks restarts the count.
- Up held 30 ticks:
  - press pulse at tick T;
  - repeats at T+8, T+12, T+16, T+20, T+24, T+28;
  - release stops pulses; no pulse on release.
- Mode held 30 ticks (mask 0): exactly one pulse, no repeats. Up and down pressed in the same cycle pulse in the same cycle.
- i_rst asserted at T+10 of an up hold: outputs clear on the next edge. Held button yields a new press 3 ticks after reset deasserts; repeats restart from delay 8.
